// File: rtl/nes_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nes_bus_pkg
// Brief    : Shared NES bus constants and the sprite DMA state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package nes_bus_pkg;

    localparam logic [15:0] SPR_DMA_REG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR    = 16'h2004;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    typedef enum logic [2:0] {
        SPR_IDLE   = 3'd0,
        SPR_ALIGN  = 3'd1,
        SPR_ALIGN2 = 3'd2,
        SPR_READ   = 3'd3,
        SPR_WRITE  = 3'd4
    } spr_state_t;

endpackage
`default_nettype wire

// File: rtl/spr_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : spr_dma_if
// Brief    : Arbitrated-bus snoop plus sprite master port of nes_bus.
// Revision : 1.0 - initial release
// ============================================================================
interface spr_dma_if;
    logic [15:0] i_bus_addr;
    logic        i_bus_wn;
    logic [7:0]  i_bus_wdata;
    logic        o_spr_req;
    logic        i_spr_gnt;
    logic [15:0] o_spr_addr;
    logic        o_spr_wn;
    logic [7:0]  o_spr_wdata;
    logic [7:0]  i_spr_rdata;
    logic        o_busy;

    modport master (
        input  i_bus_addr, i_bus_wn, i_bus_wdata, i_spr_gnt, i_spr_rdata,
        output o_spr_req, o_spr_addr, o_spr_wn, o_spr_wdata, o_busy
    );

    modport slave (
        output i_bus_addr, i_bus_wn, i_bus_wdata, i_spr_gnt, i_spr_rdata,
        input  o_spr_req, o_spr_addr, o_spr_wn, o_spr_wdata, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/spr_dma_trig.sv
`default_nettype none
// ============================================================================
// Module   : spr_dma_trig
// Brief    : $4014 write decode, rising-edge start, page latch, and the
//            odd-cycle parity tracker (SPR_DMA_ODD_ALIGN_EN).
// Revision : 1.0 - initial release
// ============================================================================
module spr_dma_trig
    import nes_bus_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_bus_addr,
    input  logic        i_bus_wn,
    input  logic [7:0]  i_bus_wdata,
    input  logic        i_req,
    input  logic        i_idle,
    output logic        o_start,
    output logic [7:0]  o_page,
    output logic        o_odd
);

    logic       w_hit;
    logic       r_hit_d;
    logic [7:0] r_page;

    // Our own bus cycles must never look like a CPU trigger.
    assign w_hit   = (i_bus_addr == SPR_DMA_REG_ADDR) && (i_bus_wn == BUS_WRITE) && !i_req;
    assign o_start = w_hit && !r_hit_d && i_idle;
    assign o_page  = r_page;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hit_d <= 1'b0;
            r_page  <= 8'h00;
        end else begin
            r_hit_d <= w_hit;
            if (o_start) begin
                r_page <= i_bus_wdata;
            end
        end
    end

`ifdef SPR_DMA_ODD_ALIGN_EN
    logic r_parity;
    logic r_odd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_parity <= 1'b0;
            r_odd    <= 1'b0;
        end else begin
            r_parity <= !r_parity;
            if (o_start) begin
                r_odd <= r_parity;
            end
        end
    end

    assign o_odd = r_odd;
`else
    assign o_odd = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/spr_dma.sv
`default_nettype none
// ============================================================================
// Module   : spr_dma
// Brief    : Sprite (OAM) DMA engine; copies a CPU page to PPU $2004.
//            Optional odd-cycle alignment via SPR_DMA_ODD_ALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spr_dma
    import nes_bus_pkg::*;
#(
    parameter int OAM_BYTES = 256
)
(
    input  logic      i_clk,
    input  logic      i_rst,
    spr_dma_if.master bus
);

    localparam logic [7:0] C_LAST = 8'(OAM_BYTES - 1);

    spr_state_t  r_state;
    spr_state_t  w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  r_data;
    logic [7:0]  w_page;
    logic        w_start;
    logic        w_odd;
    logic        w_req;
    logic        w_wn;
    logic [15:0] w_addr;
    logic [7:0]  w_wdata;
    logic        w_cnt_inc;
    logic        w_capture;

    spr_dma_trig u_trig (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_bus_addr  (bus.i_bus_addr),
        .i_bus_wn    (bus.i_bus_wn),
        .i_bus_wdata (bus.i_bus_wdata),
        .i_req       (w_req),
        .i_idle      (r_state == SPR_IDLE),
        .o_start     (w_start),
        .o_page      (w_page),
        .o_odd       (w_odd)
    );

    // Outputs decode from registers only; a denied grant simply repeats the cycle.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_wn         = BUS_READ;
        w_addr       = 16'h0000;
        w_wdata      = 8'h00;
        w_cnt_inc    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            SPR_IDLE: begin
                if (w_start) begin
                    w_state_next = SPR_ALIGN;
                end
            end
            SPR_ALIGN: begin
                w_req  = 1'b1;
                w_addr = {w_page, 8'h00};
                if (bus.i_spr_gnt) begin
                    w_state_next = w_odd ? SPR_ALIGN2 : SPR_READ;
                end
            end
            SPR_ALIGN2: begin
                w_req  = 1'b1;
                w_addr = {w_page, 8'h00};
                if (bus.i_spr_gnt) begin
                    w_state_next = SPR_READ;
                end
            end
            SPR_READ: begin
                w_req  = 1'b1;
                w_addr = {w_page, r_cnt};
                if (bus.i_spr_gnt) begin
                    w_capture    = 1'b1;
                    w_state_next = SPR_WRITE;
                end
            end
            SPR_WRITE: begin
                w_req   = 1'b1;
                w_wn    = BUS_WRITE;
                w_addr  = OAM_DATA_ADDR;
                w_wdata = r_data;
                if (bus.i_spr_gnt) begin
                    w_cnt_inc    = 1'b1;
                    w_state_next = (r_cnt == C_LAST) ? SPR_IDLE : SPR_READ;
                end
            end
            default: w_state_next = SPR_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SPR_IDLE;
            r_cnt   <= 8'h00;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_cnt <= 8'h00;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_capture) begin
                r_data <= bus.i_spr_rdata;
            end
        end
    end

    assign bus.o_spr_req   = w_req;
    assign bus.o_spr_addr  = w_addr;
    assign bus.o_spr_wn    = w_wn;
    assign bus.o_spr_wdata = w_wdata;
    assign bus.o_busy      = w_req;

endmodule
`default_nettype wire
